// File: rtl/fetch_res_queue.sv
// fetch_res_queue: slices fetch words into FETCH_WIDTH slots with PC/prediction valids and buffers packets in a DEPTH-entry FIFO.
// Define FETCH_QUEUE_BYPASS_EN to present a qualifying packet combinationally when the queue is empty.
module fetch_res_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH       = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [63:0]                       io_i_pc,
    input  logic                              io_i_fetch_valid,
    output logic                              io_o_fetch_ready,
    input  logic                              io_i_flush,
    input  logic [32*FETCH_WIDTH-1:0]         io_i_fetch_res,
    input  logic                              io_i_branch_predict_pack_valid,
    input  logic [63:0]                       io_i_branch_predict_pack_target,
    input  logic [3:0]                        io_i_branch_predict_pack_branch_type,
    input  logic [$clog2(FETCH_WIDTH)-1:0]    io_i_branch_predict_pack_select,
    input  logic                              io_i_branch_predict_pack_taken,
    output logic                              io_o_fetch_pack_valid,
    input  logic                              io_i_fetch_pack_ready,
    output logic [FETCH_WIDTH-1:0]            io_o_fetch_pack_bits_valids,
    output logic [63:0]                       io_o_fetch_pack_bits_pc,
    output logic [32*FETCH_WIDTH-1:0]         io_o_fetch_pack_bits_insts,
    output logic                              io_o_fetch_pack_bits_branch_predict_pack_valid,
    output logic [63:0]                       io_o_fetch_pack_bits_branch_predict_pack_target,
    output logic [3:0]                        io_o_fetch_pack_bits_branch_predict_pack_branch_type,
    output logic [$clog2(FETCH_WIDTH)-1:0]    io_o_fetch_pack_bits_branch_predict_pack_select,
    output logic                              io_o_fetch_pack_bits_branch_predict_pack_taken,
    output logic [$clog2(DEPTH+1)-1:0]        io_o_count
);
    localparam int FW = FETCH_WIDTH;
    localparam int SW = $clog2(FW);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [63:0]     pc;
        logic [FW-1:0]   valids;
        logic [32*FW-1:0] insts;
        logic            bp_valid;
        logic [63:0]     bp_target;
        logic [3:0]      bp_type;
        logic [SW-1:0]   bp_select;
        logic            bp_taken;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          in_e, out_e;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   off;
    logic            empty, push, pop, pop_mem, wr_en, bypass;

    always_comb begin
        off              = io_i_pc[SW+1:2];
        in_e.pc          = {io_i_pc[63:SW+2], {(SW+2){1'b0}}};
        in_e.insts       = io_i_fetch_res;
        in_e.bp_valid    = io_i_branch_predict_pack_valid;
        in_e.bp_target   = io_i_branch_predict_pack_target;
        in_e.bp_type     = io_i_branch_predict_pack_branch_type;
        in_e.bp_select   = io_i_branch_predict_pack_select;
        in_e.bp_taken    = io_i_branch_predict_pack_taken;
        in_e.valids      = '0;
        // Slots before the PC offset and after a taken predicted branch are dead.
        for (int k = 0; k < FW; k++)
            in_e.valids[k] = (SW'(k) >= off) && !(io_i_branch_predict_pack_valid &&
                             io_i_branch_predict_pack_taken && SW'(k) > io_i_branch_predict_pack_select);
    end

    assign empty            = (count_q == '0);
    assign io_o_fetch_ready = (count_q != CW'(DEPTH));
    assign push             = io_i_fetch_valid & io_o_fetch_ready & ~io_i_flush & (|in_e.valids);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & push;
`else
    assign bypass = 1'b0;
`endif

    assign out_e                 = bypass ? in_e : mem_q[rd_ptr_q];
    assign io_o_fetch_pack_valid = (~empty | bypass) & ~io_i_flush;
    assign pop                   = io_o_fetch_pack_valid & io_i_fetch_pack_ready;
    assign pop_mem               = pop & ~empty;
    assign wr_en                 = push & ~(bypass & pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop_mem);
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        count_d  = count_q + CW'(wr_en) - CW'(pop_mem);
        if (io_i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= in_e;
        end
    end

    assign io_o_fetch_pack_bits_valids                      = out_e.valids;
    assign io_o_fetch_pack_bits_pc                          = out_e.pc;
    assign io_o_fetch_pack_bits_insts                       = out_e.insts;
    assign io_o_fetch_pack_bits_branch_predict_pack_valid       = out_e.bp_valid;
    assign io_o_fetch_pack_bits_branch_predict_pack_target      = out_e.bp_target;
    assign io_o_fetch_pack_bits_branch_predict_pack_branch_type = out_e.bp_type;
    assign io_o_fetch_pack_bits_branch_predict_pack_select      = out_e.bp_select;
    assign io_o_fetch_pack_bits_branch_predict_pack_taken       = out_e.bp_taken;
    assign io_o_count                                       = count_q;
endmodule

// File: tb/tb_fetch_res_queue.sv
// tb_fetch_res_queue: directed self-checking bench for fetch_res_queue (FW=2, DEPTH=4).
// Bypass checks run only when FETCH_QUEUE_BYPASS_EN is defined.
module tb_fetch_res_queue;
    logic        clock, reset;
    logic [63:0] pc;
    logic        fv, fetch_ready, flush;
    logic [63:0] fetch_res;
    logic        bp_valid, bp_taken, bp_select;
    logic [63:0] bp_target;
    logic [3:0]  bp_type;
    logic        out_valid, out_ready;
    logic [1:0]  out_valids;
    logic [63:0] out_pc, out_insts, out_target;
    logic        out_bp_valid, out_select, out_taken;
    logic [3:0]  out_type;
    logic [2:0]  count;
    int          checks = 0, failures = 0;

    fetch_res_queue #(.FETCH_WIDTH(2), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .io_i_pc(pc), .io_i_fetch_valid(fv),
        .io_o_fetch_ready(fetch_ready), .io_i_flush(flush), .io_i_fetch_res(fetch_res),
        .io_i_branch_predict_pack_valid(bp_valid), .io_i_branch_predict_pack_target(bp_target),
        .io_i_branch_predict_pack_branch_type(bp_type), .io_i_branch_predict_pack_select(bp_select),
        .io_i_branch_predict_pack_taken(bp_taken), .io_o_fetch_pack_valid(out_valid),
        .io_i_fetch_pack_ready(out_ready), .io_o_fetch_pack_bits_valids(out_valids),
        .io_o_fetch_pack_bits_pc(out_pc), .io_o_fetch_pack_bits_insts(out_insts),
        .io_o_fetch_pack_bits_branch_predict_pack_valid(out_bp_valid),
        .io_o_fetch_pack_bits_branch_predict_pack_target(out_target),
        .io_o_fetch_pack_bits_branch_predict_pack_branch_type(out_type),
        .io_o_fetch_pack_bits_branch_predict_pack_select(out_select),
        .io_o_fetch_pack_bits_branch_predict_pack_taken(out_taken),
        .io_o_count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [63:0] p, input logic v, input logic r);
        pc        = p;
        fv        = v;
        out_ready = r;
        fetch_res = {p[31:0] + 32'd4, p[31:0]};
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; bp_valid = 1'b0; bp_taken = 1'b0; bp_select = 1'b0;
        bp_target = '0; bp_type = '0;
        drive(64'h0, 1'b0, 1'b0);
        #12;
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", fetch_ready, 1);
        check("rst_pc", out_pc, 0);
        check("rst_valids", out_valids, 0);
        reset = 1'b1;
        cyc();
        // Unaligned PC: slot 0 masked off
        drive(64'h80000004, 1'b1, 1'b0);
        fetch_res = 64'h00B50533_00000013;
        cyc();
        fv = 1'b0;
        check("p1_valid", out_valid, 1);
        check("p1_pc", out_pc, 64'h80000000);
        check("p1_valids", out_valids, 2'b10);
        check("p1_inst1", out_insts[63:32], 32'h00B50533);
        check("p1_count", count, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("p1_pop_count", count, 0);
        check("p1_pop_valid", out_valid, 0);
        // Taken prediction truncates slots after select
        bp_valid = 1'b1; bp_taken = 1'b1; bp_select = 1'b0; bp_target = 64'h1234; bp_type = 4'h5;
        drive(64'h80000000, 1'b1, 1'b0);
        cyc();
        check("bp0_valids", out_valids, 2'b01);
        check("bp0_target", out_target, 64'h1234);
        check("bp0_type", out_type, 4'h5);
        check("bp0_taken", out_taken, 1);
        bp_select = 1'b1;
        out_ready = 1'b1;
        cyc();
        check("bp1_valids", out_valids, 2'b11);
        check("bp1_select", out_select, 1);
        check("bp1_count", count, 1);
        fv = 1'b0;
        cyc();
        check("bp_drain", count, 0);
        // All-zero mask: accepted but dropped
        bp_select = 1'b0;
        drive(64'h80000004, 1'b1, 1'b0);
        check("zmask_ready", fetch_ready, 1);
        cyc();
        check("zmask_count", count, 0);
        check("zmask_valid", out_valid, 0);
        bp_valid = 1'b0; bp_taken = 1'b0;
        // Fill to full
        for (int i = 0; i < 4; i++) begin
            drive(64'h1000 + 64'(8 * i), 1'b1, 1'b0);
            cyc();
        end
        check("full_count", count, 4);
        check("full_ready", fetch_ready, 0);
        drive(64'h1020, 1'b1, 1'b0);
        cyc();
        check("full_refuse", count, 4);
        check("full_head", out_pc, 64'h1000);
        drive(64'h1020, 1'b1, 1'b1);
        cyc();
        check("full_poprefuse", count, 3);
        fv = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("drain_pc", out_pc, 64'h1000 + 64'(8 * i));
            check("drain_cnt", count, 3'(4 - i));
            cyc();
        end
        check("drain_empty", count, 0);
        // Steady push/pop at count 2
        drive(64'h2000, 1'b1, 1'b0); cyc();
        drive(64'h2008, 1'b1, 1'b0); cyc();
        for (int i = 0; i < 10; i++) begin
            drive(64'h2010 + 64'(8 * i), 1'b1, 1'b1);
            check("ss_head", out_pc, 64'h2000 + 64'(8 * i));
            cyc();
            check("ss_count", count, 2);
        end
        fv = 1'b0;
        check("ss_tail0", out_pc, 64'h2050);
        cyc();
        check("ss_tail1", out_pc, 64'h2058);
        cyc();
        check("ss_empty", count, 0);
        // Flush with count 3 and incoming packet
        for (int i = 0; i < 3; i++) begin
            drive(64'h3000 + 64'(8 * i), 1'b1, 1'b0);
            cyc();
        end
        check("fl_pre", count, 3);
        drive(64'h4000, 1'b1, 1'b1);
        flush = 1'b1;
        #1;
        check("fl_valid", out_valid, 0);
        cyc();
        flush = 1'b0;
        drive(64'h0, 1'b0, 1'b0);
        check("fl_count", count, 0);
        check("fl_valid2", out_valid, 0);
        cyc();
        check("fl_never", out_valid, 0);
        // Asynchronous reset mid-operation
        drive(64'h5000, 1'b1, 1'b0);
        cyc();
        fv = 1'b0;
        check("ar_pre", count, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_valid", out_valid, 0);
        check("ar_pc", out_pc, 0);
        check("ar_ready", fetch_ready, 1);
        reset = 1'b1;
        cyc();
`ifdef FETCH_QUEUE_BYPASS_EN
        drive(64'h100, 1'b1, 1'b1);
        #1;
        check("byp_valid", out_valid, 1);
        check("byp_pc", out_pc, 64'h100);
        cyc();
        check("byp_count", count, 0);
        drive(64'h100, 1'b1, 1'b0);
        #1;
        check("byp_hold_valid", out_valid, 1);
        cyc();
        fv = 1'b0;
        check("byp_written", count, 1);
        check("byp_stored_pc", out_pc, 64'h100);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_res_queue.md
# fetch_res_queue

Parametrised successor to the single-packet fetch result stage: it slices each instruction-memory fetch word into `FETCH_WIDTH` 32-bit instruction slots, computes per-slot valids from the PC offset and the branch prediction, and buffers packets in a `DEPTH`-entry FIFO. Decode drains the FIFO through a valid/ready handshake instead of a stall input. Sits between the I-cache/fetch response and the decode stage. Flush discards all buffered packets.

## Interface
- `FETCH_WIDTH`, default 2: instruction slots per packet; power of 2, 2..8. Let `FW` = `FETCH_WIDTH`, `SW` = clog2(FW).
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `io_i_pc` input 64: fetch PC, byte address.
- `io_i_fetch_valid` input 1: fetch response present this cycle.
- `io_o_fetch_ready` output 1: queue accepts a packet.
- `io_i_flush` input 1: discard contents and input.
- `io_i_fetch_res` input 32*FW: slot k is bits [32k+31:32k].
- `io_i_branch_predict_pack_valid` input 1; `_target` input 64; `_branch_type` input 4; `_select` input SW (slot index of the predicted branch); `_taken` input 1.
- `io_o_fetch_pack_valid` output 1: head packet valid.
- `io_i_fetch_pack_ready` input 1: decode accepts the head packet.
- `io_o_fetch_pack_bits_valids` output FW: per-slot valid of the head.
- `io_o_fetch_pack_bits_pc` output 64: aligned packet PC.
- `io_o_fetch_pack_bits_insts` output 32*FW.
- `io_o_fetch_pack_bits_branch_predict_pack_*` outputs: the head's prediction fields, widths as the inputs.
- `io_o_count` output clog2(DEPTH+1): occupancy.

## Operation
- Offset `off = io_i_pc[SW+1:2]`; aligned PC = `{io_i_pc[63:SW+2], (SW+2)'b0}`.
- Slot mask: slot k valid iff `k >= off`; additionally, if prediction valid and taken, slot k valid only if `k <= select`. Slots with valid 0 carry instruction data unchanged.
- Push = `io_i_fetch_valid & io_o_fetch_ready & ~io_i_flush & (mask != 0)`. A packet whose mask is all-zero is accepted (consumes no entry) and dropped.
- Pop = `io_o_fetch_pack_valid & io_i_fetch_pack_ready`.
- `io_o_fetch_ready = (count != DEPTH)`. When full, a push is refused even if a pop occurs the same cycle.
- Simultaneous push and pop with count ≥1: count unchanged; head advances, tail writes.
- Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush: `io_o_fetch_pack_valid` is forced 0 in the flush cycle; pointers and count clear at the next edge; no push or pop takes effect in that cycle.
- Entries store the aligned PC, mask, instructions and prediction pack verbatim.

## Timing
- Reset values: count 0, pointers 0, `io_o_fetch_pack_valid` 0, `io_o_fetch_ready` 1, valids 0, all data outputs 0 (storage is reset).
- Latency: a packet pushed at edge t is presented at the output from cycle t+1 (non-bypass build).
- Output holds stable while valid and not ready.
- Reset asserted mid-operation empties the queue asynchronously; outputs return to reset values without waiting for a clock.
- Flush has priority over push, pop and bypass.

## Configuration
- `FETCH_QUEUE_BYPASS_EN`: when defined and the queue is empty, a qualifying input packet is presented combinationally on the output in the same cycle; if popped that cycle it is not written (count stays 0); otherwise it is written as normal. When undefined, minimum latency is one cycle and output depends only on stored state.

## Test plan
- Reset then FW=2: pc=0x80000004, fetch_res=0x00B50533_00000013, fetch_valid=1 -> next cycle valid=1, pc=0x80000000, valids=2'b10, insts[1]=0x00B50533, count=1.
- Prediction taken, select=0, pc=0x80000000 -> stored valids=2'b01; select=1 -> 2'b11.
- Push 4 packets with decode ready=0 -> count=4, fetch_ready=0; 5th packet not accepted; raise ready -> packets drain in order, one per cycle, count 4→0.
- Push and pop every cycle at count=2 for 10 cycles -> count stays 2, pointers wrap, PC order preserved.
- Flush with count=3 and fetch_valid=1 -> output valid=0 that cycle, count=0 next cycle, flushed input never appears.
- With FETCH_QUEUE_BYPASS_EN, empty queue, ready=1, push pc=0x100 -> output valid same cycle with pc=0x100, count remains 0; ready=0 -> count=1 next cycle.
